// File: rtl/echo_multi.sv
// rtl/echo_multi.sv - multi-channel echo server: per-channel FIFOs drained round-robin onto one indication
// Define ECHO_MULTI_STATS_EN to add the echo_count / drop_count outputs.
module echo_multi #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   parameter int NCHAN = 2,
   localparam int CW = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
   input  logic                   CLK,
   input  logic                   nRST,
   input  logic [NCHAN-1:0]       say__ENA,
   input  logic [NCHAN*WIDTH-1:0] say_v,
   output logic [NCHAN-1:0]       say__RDY,
   input  logic                   respond_rule__ENA,
   output logic                   respond_rule__RDY,
   output logic                   ind_echo__ENA,
   output logic [WIDTH-1:0]       ind_echo_v,
   output logic [CW-1:0]          ind_echo_chan,
   input  logic                   ind_echo__RDY
`ifdef ECHO_MULTI_STATS_EN
   ,
   output logic [31:0]            echo_count,
   output logic [31:0]            drop_count
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
   localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);

   logic [WIDTH-1:0] mem [NCHAN][DEPTH];
   logic [PW-1:0]    rd_ptr [NCHAN];
   logic [PW-1:0]    wr_ptr [NCHAN];
   logic [PW:0]      count [NCHAN];
   logic [CW-1:0]    last_grant;

   logic [NCHAN-1:0] nonempty;
   logic [NCHAN-1:0] push;
   logic [NCHAN-1:0] pop;
   logic [CW-1:0]    grant;
   logic [CW-1:0]    scan_idx;
   logic             fire;

   always_comb begin
      for (int i = 0; i < NCHAN; i++) begin
         say__RDY[i] = (count[i] != CNT_FULL);
         nonempty[i] = (count[i] != '0);
      end
   end

   // Scan from the far end backwards so the last hit is the first channel after last_grant.
   always_comb begin
      grant    = '0;
      scan_idx = '0;
      for (int k = NCHAN; k >= 1; k--) begin
         scan_idx = CW'((int'(last_grant) + k) % NCHAN);
         if (nonempty[scan_idx])
            grant = scan_idx;
      end
   end

   assign respond_rule__RDY = (|nonempty) & ind_echo__RDY;
   assign fire              = respond_rule__ENA & respond_rule__RDY & nRST;
   assign push              = say__ENA & say__RDY;

   always_comb begin
      pop = '0;
      if (fire)
         pop[grant] = 1'b1;
   end

   assign ind_echo__ENA = fire;
   assign ind_echo_v    = fire ? mem[grant][rd_ptr[grant]] : '0;
   assign ind_echo_chan = fire ? grant : '0;

   always_ff @(posedge CLK) begin
      for (int i = 0; i < NCHAN; i++)
         if (nRST && push[i])
            mem[i][wr_ptr[i]] <= say_v[i*WIDTH +: WIDTH];
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         for (int i = 0; i < NCHAN; i++) begin
            rd_ptr[i] <= '0;
            wr_ptr[i] <= '0;
            count[i]  <= '0;
         end
         last_grant <= CW'(NCHAN - 1);
      end else begin
         for (int i = 0; i < NCHAN; i++) begin
            if (push[i])
               wr_ptr[i] <= wr_ptr[i] + PTR_ONE;
            if (pop[i])
               rd_ptr[i] <= rd_ptr[i] + PTR_ONE;
            if (push[i] && !pop[i])
               count[i] <= count[i] + CNT_ONE;
            else if (pop[i] && !push[i])
               count[i] <= count[i] - CNT_ONE;
         end
         if (fire)
            last_grant <= grant;
      end
   end

`ifdef ECHO_MULTI_STATS_EN
   logic [NCHAN-1:0] drop;
   assign drop = say__ENA & ~say__RDY;

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         echo_count <= '0;
         drop_count <= '0;
      end else begin
         if (fire)
            echo_count <= echo_count + 32'd1;
         drop_count <= drop_count + 32'($countones(drop));
      end
   end
`endif

endmodule
